// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, encoder error codes and small field helpers
// used by the instruction encoder and its output buffer.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_OPCODE = 2'b01,
    ERR_ALIGN  = 2'b10,
    ERR_RANGE  = 2'b11
  } enc_err_e;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_R,
    FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } fifo_entry_t;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM:  return FMT_I;
      OP_STORE:         return FMT_S;
      OP_BRANCH:        return FMT_B;
      OP_LUI, OP_AUIPC: return FMT_U;
      OP_JAL:           return FMT_J;
      OP_REG:           return FMT_R;
      default:          return FMT_BAD;
    endcase
  endfunction

  // True when v is a sign-extension of its low 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int bits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= bits - 1 && v[i] != v[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Request, output-stream and error signals between the program generator
// (master) and the instruction encoder (slave).
interface instruction_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] err_count;

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err_valid, err_code, err_count
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr, err_valid, err_code, err_count
  );
endinterface

// File: rtl/instr_word_fifo.sv
// Synchronous FIFO of {addr, instr} entries with a registered not-full flag so
// the upstream ready never depends combinationally on the downstream pop.
module instr_word_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  fifo_entry_t data_i,
  input  logic        pop_i,
  output fifo_entry_t data_o,
  output logic        valid_o,
  output logic        not_full_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fifo_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             not_full_q;
  logic             do_push, do_pop;

  assign valid_o    = (count_q != '0);
  assign not_full_o = not_full_q;
  assign do_push    = push_i && not_full_q;
  assign do_pop     = pop_i && valid_o;
  assign data_o     = valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      not_full_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      not_full_q <= (count_d < DEPTH_C);
    end
  end

  // NOTE: storage is not reset; an empty FIFO presents zero at the head instead.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/instruction_encoder.sv
// Streaming RV32I encoder: validates decoded fields, packs the instruction word and
// queues it with a sequential address for the instruction-memory writer.
module instruction_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input logic                  clk,
  input logic                  rst,
  instruction_encoder_if.slave bus
);
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  assign op  = bus.in_opcode;
  assign f3  = bus.in_funct3;
  assign f7  = bus.in_funct7;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign imm = bus.in_imm;

  fmt_e        fmt;
  enc_err_e    err;
  logic [31:0] word;

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    fmt  = fmt_of(op);
    err  = ERR_NONE;
    word = '0;
    case (fmt)
      FMT_I: begin
        word = {imm[11:0], rs1, f3, rd, op};
        if (!fits_signed(imm, 12)) err = ERR_RANGE;
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        if (!fits_signed(imm, 12)) err = ERR_RANGE;
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        if (imm[0])                     err = ERR_ALIGN;
        else if (!fits_signed(imm, 13)) err = ERR_RANGE;
      end
      FMT_U: begin
        word = {imm[31:12], rd, op};
        if (imm[11:0] != 12'd0) err = ERR_ALIGN;
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        if (imm[0])                     err = ERR_ALIGN;
        else if (!fits_signed(imm, 21)) err = ERR_RANGE;
      end
      FMT_R: word = {f7, rs2, rs1, f3, rd, op};
      default: err = ERR_OPCODE;
    endcase
  end

  logic        in_ready, accept, push, head_valid;
  fifo_entry_t push_entry, head;
  logic [31:0] addr_q, addr_d;
  logic        err_valid_q, err_valid_d;
  enc_err_e    err_code_q, err_code_d;
  logic [15:0] err_count_q, err_count_d;

  assign accept     = bus.in_valid && in_ready;
  assign push       = accept && (err == ERR_NONE);
  assign push_entry = '{addr: addr_q, instr: word};

  instr_word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .data_i    (push_entry),
    .pop_i     (bus.out_ready),
    .data_o    (head),
    .valid_o   (head_valid),
    .not_full_o(in_ready)
  );

  always_comb begin
    addr_d      = push ? addr_q + 32'd4 : addr_q;
    err_valid_d = accept && (err != ERR_NONE);
    err_code_d  = err_valid_d ? err : ERR_NONE;
    err_count_d = err_count_q;
    if (err_valid_d && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= BASE_ADDR;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_count_q <= '0;
    end else begin
      addr_q      <= addr_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = head_valid;
  assign bus.out_instr = head.instr;
  assign bus.out_addr  = head.addr;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed scenarios followed by
// randomized requests compared against an arithmetic reference model.
module tb_instruction_encoder;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_encoder_if bus ();

  instruction_encoder #(
    .FIFO_DEPTH(DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_addr;
  int          m_errs;
  logic [1:0]  m_last_err;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoder written from the field-placement rules with shifts and masks.
  function automatic void ref_encode(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [31:0] imm,
                                     output logic [31:0] word, output logic [1:0] err);
    int s;
    logic [31:0] u, regs;
    u    = imm;
    s    = $signed(imm);
    err  = 2'd0;
    regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
    word = 32'd0;
    case (op)
      7'b0000011, 7'b0010011: begin
        if (s < -2048 || s > 2047) err = 2'd3;
        word = ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
      end
      7'b0100011: begin
        if (s < -2048 || s > 2047) err = 2'd3;
        word = (((u >> 5) & 32'h7F) << 25) | regs | ((u & 32'h1F) << 7) | 32'(op);
      end
      7'b1100011: begin
        if (u[0]) err = 2'd2;
        else if (s < -4096 || s > 4094) err = 2'd3;
        word = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | regs |
               (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 32'(op);
      end
      7'b0110111, 7'b0010111: begin
        if ((u & 32'hFFF) != 0) err = 2'd2;
        word = (u & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
      end
      7'b1101111: begin
        if (u[0]) err = 2'd2;
        else if (s < -(1 << 20) || s > (1 << 20) - 2) err = 2'd3;
        word = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20) |
               (((u >> 12) & 255) << 12) | (32'(rd) << 7) | 32'(op);
      end
      7'b0110011: word = (32'(f7) << 25) | regs | (32'(rd) << 7) | 32'(op);
      default: err = 2'd1;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_addr     = BASE;
    m_errs     = 0;
    m_last_err = 2'd0;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    bus.in_opcode = op;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
    bus.in_valid  = 1'b1;
  endtask

  // Record the effect of the request currently on the bus being accepted.
  task automatic model_accept();
    logic [31:0] w;
    logic [1:0]  e;
    exp_t        ent;
    ref_encode(bus.in_opcode, bus.in_funct3, bus.in_funct7, bus.in_rd, bus.in_rs1,
               bus.in_rs2, bus.in_imm, w, e);
    m_last_err = e;
    if (e == 2'd0) begin
      ent.addr  = m_addr;
      ent.instr = w;
      q.push_back(ent);
      m_addr = m_addr + 32'd4;
    end else if (m_errs != 65535) begin
      m_errs++;
    end
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
    drive(op, f3, f7, rd, rs1, rs2, imm);
    model_accept();
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("err_valid", 32'(bus.err_valid), 32'(m_last_err != 2'd0));
    check("err_code", 32'(bus.err_code), 32'(m_last_err));
    check("err_count", 32'(bus.err_count), 32'(m_errs));
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    e = q.pop_front();
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_instr"}, bus.out_instr, e.instr);
    check({tag, "_addr"}, bus.out_addr, e.addr);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic head_lit(input string tag, input logic [31:0] instr, input logic [31:0] addr);
    check({tag, "_lit_instr"}, bus.out_instr, instr);
    check({tag, "_lit_addr"}, bus.out_addr, addr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [6:0] ops [8];
    int         bnd [14];
    logic [6:0] op;
    logic [31:0] imm;

    ops = '{7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};
    bnd = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4098,
            (1 << 20) - 2, (1 << 20), -(1 << 20), -(1 << 20) - 2, 32'h1234_5000, 32'h1234_5001};

    bus.out_ready = 1'b0;
    drive(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    bus.in_valid = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_addr", bus.out_addr, 32'd0);
    check("rst_err_valid", 32'(bus.err_valid), 32'd0);
    check("rst_err_code", 32'(bus.err_code), 32'd0);
    check("rst_err_count", 32'(bus.err_count), 32'd0);
    rst = 1'b0;

    // addi x1,x0,5
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    head_lit("addi", 32'h0050_0093, 32'h0);
    pop_check("addi");

    // sw x2,8(x1) then beq x0,x0,-4
    send(7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    send(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    head_lit("sw", 32'h0020_A423, 32'h4);
    pop_check("sw");
    head_lit("beq", 32'hFE00_0EE3, 32'h8);
    pop_check("beq");

    // jal x1,2048; misaligned jal; out-of-range addi; then a good word
    send(7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    head_lit("jal", 32'h0010_00EF, 32'hC);
    pop_check("jal");
    send(7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
    check("jal_odd_code", 32'(bus.err_code), 32'd2);
    check("jal_odd_no_word", 32'(bus.out_valid), 32'd0);
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    check("addi_range_code", 32'(bus.err_code), 32'd3);
    check("err_count_two", 32'(bus.err_count), 32'd2);
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    head_lit("after_err", 32'h0050_0093, 32'h10);
    pop_check("after_err");

    // Bad opcode: one-cycle error pulse, nothing buffered
    send(7'b1111111, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    check("badop_code", 32'(bus.err_code), 32'd1);
    check("badop_no_word", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("badop_pulse_end", 32'(bus.err_valid), 32'd0);
    check("badop_code_clear", 32'(bus.err_code), 32'd0);

    // Backpressure: fill, hold a third request, then drain
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    send(7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(7'b0010011, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3);
    @(posedge clk);
    @(negedge clk);
    check("full_hold_ready", 32'(bus.in_ready), 32'd0);
    check("full_head_stable", bus.out_instr, q[0].instr);
    check("full_head_addr", bus.out_addr, 32'h14);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    void'(q.pop_front());
    check("drain_ready_back", 32'(bus.in_ready), 32'd1);
    check("drain_second_instr", bus.out_instr, q[0].instr);
    check("drain_second_addr", bus.out_addr, 32'h18);
    model_accept();
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    void'(q.pop_front());
    check("third_addr_lit", bus.out_addr, 32'h1C);
    pop_check("third");
    check("drained_empty", 32'(bus.out_valid), 32'd0);

    // Reset mid-stream drops buffered words, error count and address
    send(7'b0110111, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'hABCD_E000);
    send(7'b0110011, 3'd0, 7'd32, 5'd5, 5'd6, 5'd7, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_err_count", 32'(bus.err_count), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    head_lit("post_rst", 32'h0050_0093, BASE);
    pop_check("post_rst");

    // Randomized requests against the reference model
    for (int n = 0; n < 300; n++) begin
      int k;
      k = $urandom_range(0, 9);
      op = (k < 8) ? ops[k] : 7'($urandom);
      case ($urandom_range(0, 3))
        0:       imm = 32'($urandom_range(0, 64)) - 32'd32;
        1:       imm = bnd[$urandom_range(0, 13)];
        2:       imm = $urandom;
        default: imm = $urandom & 32'hFFFF_F000;
      endcase
      send(op, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
      if (q.size() == DEPTH || (q.size() > 0 && $urandom_range(0, 1) == 1)) pop_check("rand");
    end
    while (q.size() > 0) pop_check("rand_drain");
    check("final_empty", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Streaming RV32I instruction encoder: the inverse of the core's field decoder. It accepts decoded instruction fields (opcode, funct3, funct7, register indices, full 32-bit immediate) over a valid/ready handshake, checks that the immediate is representable, packs a 32-bit instruction word, and buffers it in a small FIFO tagged with a sequential program address. It sits between the test/program-generation front end and the instruction-memory write port.

## Interface
- `FIFO_DEPTH`, default 2: output buffer entries, power of two, ≥2.
- `BASE_ADDR`, default 32'h0000_0000: address assigned to the first emitted word.
- `clk  in  1  clock; all logic on rising edge`
- `rst  in  1  reset, synchronous, active-high`
- `in_valid  in  1  field request valid`
- `in_ready  out  1  request accepted when in_valid && in_ready`
- `in_opcode  in  7  opcode`
- `in_funct3  in  3  funct3`
- `in_funct7  in  7  funct7 (R-type only)`
- `in_rd / in_rs1 / in_rs2  in  5 each  register indices`
- `in_imm  in  32  signed byte-offset / value immediate`
- `out_valid  out  1  FIFO head valid`
- `out_ready  in  1  consumer pops head when out_valid && out_ready`
- `out_instr  out  32  encoded word`
- `out_addr  out  32  address of out_instr`
- `err_valid  out  1  one-cycle pulse: accepted request rejected`
- `err_code  out  2  01 bad opcode, 10 misaligned imm, 11 imm out of range`
- `err_count  out  16  saturating count of rejected requests`

## Operation
- Formats: I {0000011, 0010011}, S {0100011}, B {1100011}, U {0110111, 0010111}, J {1101111}, R {0110011}. Any other opcode: error 01.
- I: bits[31:20]=imm[11:0]; in_funct7 ignored (shift-amount/funct7 encodings come via imm). Range −2048..2047.
- S: imm[11:5]→[31:25], imm[4:0]→[11:7]; range −2048..2047.
- B: imm[12|10:5]→[31:25], imm[4:1|11]→[11:7]; imm[0] must be 0; range −4096..4094.
- U: bits[31:12]=imm[31:12]; imm[11:0] must be 0 (else error 10).
- J: imm[20|10:1|11|19:12]→[31:12]; imm[0] must be 0; range −2^20..2^20−2.
- R: funct7, rs2, rs1, funct3, rd packed; in_imm ignored.
- Unused register fields for a format are not placed in the word.
- Error priority: 01 > 10 > 11. Rejected requests are still handshaken (consume in_ready), write nothing, do not advance address.
- Address counter: starts BASE_ADDR, +4 per word written to FIFO, wraps modulo 2^32.
- err_count saturates at 16'hFFFF.

## Timing
- Reset values: in_ready=1, out_valid=0, out_instr=0, out_addr=0, err_valid=0, err_code=0, err_count=0; FIFO emptied, address counter=BASE_ADDR.
- Latency: word accepted at edge N is visible at head (if FIFO was empty) after edge N, i.e. out_valid in cycle N+1. err_valid/err_code asserted in cycle N+1 for one cycle.
- in_ready = registered (count < FIFO_DEPTH); no combinational path from out_ready to in_ready. When full, in_ready=0 even if a pop occurs that cycle.
- Simultaneous push and pop when not full: count unchanged, order preserved.
- out_instr/out_addr stable while out_valid && !out_ready.
- Reset asserted mid-stream drops all buffered words, pending error pulse, and address state on that edge.

## Structure
- Shared package `riscv_pkg`: opcode constants (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG), encoder error-code enum.
- Sub-module `instr_word_fifo`: parameterised sync FIFO of {addr, instr} 64-bit entries with count, used once.
- Top holds combinational check/pack logic, address counter, error registers.

## Test plan
- addi x1,x0,5 (op 0010011, f3 0, rd 1, imm 5) -> out_instr 32'h0050_0093, out_addr 0x0.
- sw x2,8(x1) then beq x0,x0,−4 -> 32'h0020_A423 @0x0, 32'hFE00_0EE3 @0x4.
- jal x1,2048 -> 32'h0010_00EF; jal imm 3 -> err_code 10, no word; addi imm 2048 -> err_code 11, err_count 2, next good word still at next address.
- Opcode 7'b1111111 -> err_code 01 in cycle after accept, out_valid stays 0.
- DEPTH 2, out_ready=0, three back-to-back valid requests -> two accepted, in_ready=0; raise out_ready -> words in order at 0x0, 0x4, third accepted afterwards at 0x8.
- Two words buffered, assert rst one cycle -> out_valid=0, err_count=0, next word emitted at BASE_ADDR.
